// File: rtl/lctdly_cfg_ctrl.sv
// ============================================================================
//  Module   : lctdly_cfg_ctrl
//  Purpose  : Serial-loaded LCT/L1A match delay config with atomic apply,
//             post-apply output blanking (flush) and match statistics.
//             Statistics enabled by defining LCTDLY_CFG_STATS_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lctdly_cfg_ctrl #(
  parameter logic [21:0] DEF_CFG    = 22'h3C0000,
  parameter int          FLUSH_BASE = 96,
  parameter int          CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SDI,
  input  logic             SHIFT_EN,
  input  logic             CAPTURE,
  input  logic             LOAD,
  input  logic             CNT_CLR,
  output logic             SDO,
  output logic [3:0]       CLCT_ADJ,
  output logic [2:0]       OPT_COP,
  output logic [5:0]       DELAY,
  output logic [1:0]       XL1ADLY,
  output logic [3:0]       L1FD,
  output logic             LAT_12_5US,
  output logic             MTCH_3BX,
  output logic             USE_CLCT,
  input  logic             L1A_IN,
  input  logic             MATCH_IN,
  input  logic             DOUT_IN,
  output logic             L1A_MATCH,
  output logic             DOUT,
  output logic             BUSY,
  output logic [CNT_W-1:0] MATCH_CNT,
  output logic [CNT_W-1:0] L1A_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [21:0] shadow_q;
  logic [21:0] cfg_q;
  logic [9:0]  flush_cnt_q, flush_cnt_d;
  logic [9:0]  flush_len;
  logic        busy_q, busy_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      shadow_q <= DEF_CFG;
    end else if (CAPTURE) begin
      shadow_q <= cfg_q;
    end else if (SHIFT_EN) begin
      shadow_q <= {shadow_q[20:0], SDI};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cfg_q <= DEF_CFG;
    end else if (LOAD) begin
      cfg_q <= shadow_q;
    end
  end

  assign SDO        = shadow_q[21];
  assign CLCT_ADJ   = cfg_q[21:18];
  assign OPT_COP    = cfg_q[17:15];
  assign DELAY      = cfg_q[14:9];
  assign XL1ADLY    = cfg_q[8:7];
  assign L1FD       = cfg_q[6:3];
  assign LAT_12_5US = cfg_q[2];
  assign MTCH_3BX   = cfg_q[1];
  assign USE_CLCT   = cfg_q[0];

  // Worst case 582 fits in 10 bits, so no overflow handling is needed.
  assign flush_len = 10'(FLUSH_BASE)
                   + {4'b0, cfg_q[8:7], 4'b0}
                   + {7'b0, cfg_q[17:15]}
                   + {4'b0, cfg_q[14:9]}
                   + (cfg_q[2] ? 10'd368 : 10'd0);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_IDLE: ;
      ST_COMMIT: begin
        flush_cnt_d = flush_len;
        state_d     = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (flush_cnt_q == 10'd0) begin
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 10'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (LOAD) begin
      state_d = ST_COMMIT;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_COMMIT;
      flush_cnt_q <= 10'd0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= busy_d;
    end
  end

  // BUSY comes straight from a flop so the gating below cannot glitch.
  assign BUSY      = busy_q;
  assign L1A_MATCH = MATCH_IN & ~busy_q;
  assign DOUT      = DOUT_IN & ~busy_q;

`ifdef LCTDLY_CFG_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] match_cnt_q;
  logic [CNT_W-1:0] l1a_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST_N || CNT_CLR || LOAD) begin
      match_cnt_q <= '0;
      l1a_cnt_q   <= '0;
    end else begin
      if (L1A_MATCH && !(&match_cnt_q)) begin
        match_cnt_q <= match_cnt_q + CNT_ONE;
      end
      if (L1A_IN && !busy_q && !(&l1a_cnt_q)) begin
        l1a_cnt_q <= l1a_cnt_q + CNT_ONE;
      end
    end
  end

  assign MATCH_CNT = match_cnt_q;
  assign L1A_CNT   = l1a_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = ^{CNT_CLR, L1A_IN};
  assign MATCH_CNT    = '0;
  assign L1A_CNT      = '0;
`endif

endmodule

`default_nettype wire
